// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode definitions for decode_queue: opcode/funct constants,
// ALU/compare operation codes, operand and write-back selects, immediate
// formats, the decoded micro-op record and small helper functions.
// The M-extension codes are always defined here; whether they are decoded
// is controlled by DECODE_RV32M_EN in rv_decode_core.
package decode_queue_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 for register/immediate arithmetic
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3 for branches and JALR
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  // funct7
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operations (5-bit; M-extension occupies 16..23)
  localparam logic [4:0] ALU_OP_ADD    = 5'd0;
  localparam logic [4:0] ALU_OP_SUB    = 5'd1;
  localparam logic [4:0] ALU_OP_SLL    = 5'd2;
  localparam logic [4:0] ALU_OP_SLT    = 5'd3;
  localparam logic [4:0] ALU_OP_SLTU   = 5'd4;
  localparam logic [4:0] ALU_OP_XOR    = 5'd5;
  localparam logic [4:0] ALU_OP_SRL    = 5'd6;
  localparam logic [4:0] ALU_OP_SRA    = 5'd7;
  localparam logic [4:0] ALU_OP_OR     = 5'd8;
  localparam logic [4:0] ALU_OP_AND    = 5'd9;
  localparam logic [4:0] ALU_OP_MUL    = 5'd16;
  localparam logic [4:0] ALU_OP_MULH   = 5'd17;
  localparam logic [4:0] ALU_OP_MULHSU = 5'd18;
  localparam logic [4:0] ALU_OP_MULHU  = 5'd19;
  localparam logic [4:0] ALU_OP_DIV    = 5'd20;
  localparam logic [4:0] ALU_OP_DIVU   = 5'd21;
  localparam logic [4:0] ALU_OP_REM    = 5'd22;
  localparam logic [4:0] ALU_OP_REMU   = 5'd23;
  localparam logic [4:0] ALU_OP_INV    = 5'd31;

  // Branch compare operations (mirror the branch funct3 encodings)
  localparam logic [2:0] CBU_OP_EQ  = 3'd0;
  localparam logic [2:0] CBU_OP_NE  = 3'd1;
  localparam logic [2:0] CBU_OP_INV = 3'd2;
  localparam logic [2:0] CBU_OP_LT  = 3'd4;
  localparam logic [2:0] CBU_OP_GE  = 3'd5;
  localparam logic [2:0] CBU_OP_LTU = 3'd6;
  localparam logic [2:0] CBU_OP_GEU = 3'd7;

  // ALU operand selects and write-back source
  localparam logic [1:0] ALU_SEL1_RS1  = 2'd0;
  localparam logic [1:0] ALU_SEL1_PC   = 2'd1;
  localparam logic [1:0] ALU_SEL1_ZERO = 2'd2;
  localparam logic [1:0] ALU_SEL2_RS2  = 2'd0;
  localparam logic [1:0] ALU_SEL2_IMM  = 2'd1;
  localparam logic [1:0] WB_SEL_ALU    = 2'd0;
  localparam logic [1:0] WB_SEL_LSU    = 2'd1;
  localparam logic [1:0] WB_SEL_PC4    = 2'd2;

  typedef enum logic [2:0] {
    IMM_FMT_I,
    IMM_FMT_S,
    IMM_FMT_B,
    IMM_FMT_J,
    IMM_FMT_U,
    IMM_FMT_NONE
  } imm_fmt_e;

  // One decoded micro-op as stored in the queue (PC is kept alongside).
  typedef struct packed {
    logic        legal;
    logic [1:0]  alusel1;
    logic [1:0]  alusel2;
    logic [4:0]  alu_op;
    logic [2:0]  cmp_op;
    logic        branch;
    logic        jump;
    logic [1:0]  wb_sel;
    logic        rf_we;
    logic        lsu_we;
    logic [3:0]  mask;
    logic        sext;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decode_entry_t;

  // Value presented at the head whenever the queue is empty.
  function automatic decode_entry_t idle_entry();
    decode_entry_t e;
    e        = '0;
    e.alu_op = ALU_OP_INV;
    e.cmp_op = CBU_OP_INV;
    return e;
  endfunction

  // Base-ISA ALU op selected by funct3 alone (SUB/SRA handled by the caller).
  function automatic logic [4:0] base_alu_op(input logic [2:0] funct3);
    case (funct3)
      F3_ADD_SUB: return ALU_OP_ADD;
      F3_SLL:     return ALU_OP_SLL;
      F3_SLT:     return ALU_OP_SLT;
      F3_SLTU:    return ALU_OP_SLTU;
      F3_XOR:     return ALU_OP_XOR;
      F3_SRL_SRA: return ALU_OP_SRL;
      F3_OR:      return ALU_OP_OR;
      default:    return ALU_OP_AND;
    endcase
  endfunction

  // Immediate assembly; only instr[31:7] carries immediate bits.
  function automatic logic [31:0] gen_imm(input logic [31:7] ins, input imm_fmt_e fmt);
    case (fmt)
      IMM_FMT_I: return {{20{ins[31]}}, ins[31:20]};
      IMM_FMT_S: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_FMT_B: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_FMT_J: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_FMT_U: return {ins[31:12], 12'b0};
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Handshake and decoded-field bundle between fetch, decode_queue and execute.
// slave: the queue itself; master: the environment driving it.
interface decode_queue_if #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // fetch side
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_instr;
  logic [ADDR_W-1:0] i_pc;

  // execute side
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] o_pc;
  logic              o_legal;
  logic [1:0]        o_alusel1;
  logic [1:0]        o_alusel2;
  logic [4:0]        o_alu_op;
  logic [2:0]        o_cmp_op;
  logic              o_branch;
  logic              o_jump;
  logic [1:0]        o_wb_sel;
  logic              o_rf_we;
  logic              o_lsu_we;
  logic [3:0]        o_mask;
  logic              o_sext;
  logic [4:0]        o_rd;
  logic [4:0]        o_rs1;
  logic [4:0]        o_rs2;
  logic [31:0]       o_imm;
  logic [CNT_W-1:0]  o_count;

  modport slave (
    input  i_flush, i_valid, i_instr, i_pc, i_ready,
    output o_ready, o_valid, o_pc, o_legal, o_alusel1, o_alusel2, o_alu_op,
           o_cmp_op, o_branch, o_jump, o_wb_sel, o_rf_we, o_lsu_we, o_mask,
           o_sext, o_rd, o_rs1, o_rs2, o_imm, o_count
  );

  modport master (
    output i_flush, i_valid, i_instr, i_pc, i_ready,
    input  o_ready, o_valid, o_pc, o_legal, o_alusel1, o_alusel2, o_alu_op,
           o_cmp_op, o_branch, o_jump, o_wb_sel, o_rf_we, o_lsu_we, o_mask,
           o_sext, o_rd, o_rs1, o_rs2, o_imm, o_count
  );
endinterface

// File: rtl/decode_queue_decode_core.sv
// rv_decode_core: purely combinational RV32I decoder and immediate
// generator producing one decode_entry_t from a raw instruction.
// Optional feature macro: DECODE_RV32M_EN (decode MUL/DIV/REM family;
// when undefined those encodings decode as illegal).
module rv_decode_core
  import decode_queue_pkg::*;
(
  input  logic [31:0]   instr,
  output decode_entry_t entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  logic       legal;
  imm_fmt_e   fmt;
  logic [4:0] alu_op;
  logic [2:0] cmp_op;
  logic [1:0] sel1;
  logic [1:0] sel2;
  logic [1:0] wb_sel;
  logic       branch;
  logic       jump;
  logic       writes;
  logic       store;
  logic [3:0] mask;
  logic       sext;

  // Classify the instruction and derive raw control fields before legality gating.
  always_comb begin
    legal  = 1'b0;
    fmt    = IMM_FMT_NONE;
    alu_op = ALU_OP_ADD;
    cmp_op = CBU_OP_INV;
    sel1   = ALU_SEL1_RS1;
    sel2   = ALU_SEL2_RS2;
    wb_sel = WB_SEL_ALU;
    branch = 1'b0;
    jump   = 1'b0;
    writes = 1'b0;
    store  = 1'b0;
    mask   = 4'b0000;
    sext   = 1'b0;

    case (opcode)
      OPC_LUI: begin
        legal  = 1'b1;
        fmt    = IMM_FMT_U;
        sel1   = ALU_SEL1_ZERO;
        sel2   = ALU_SEL2_IMM;
        writes = 1'b1;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        fmt    = IMM_FMT_U;
        sel1   = ALU_SEL1_PC;
        sel2   = ALU_SEL2_IMM;
        writes = 1'b1;
      end
      OPC_JAL: begin
        legal  = 1'b1;
        fmt    = IMM_FMT_J;
        sel1   = ALU_SEL1_PC;
        sel2   = ALU_SEL2_IMM;
        jump   = 1'b1;
        wb_sel = WB_SEL_PC4;
        writes = 1'b1;
      end
      OPC_JALR: begin
        legal  = (funct3 == F3_JALR);
        fmt    = IMM_FMT_I;
        sel2   = ALU_SEL2_IMM;
        jump   = 1'b1;
        wb_sel = WB_SEL_PC4;
        writes = 1'b1;
      end
      OPC_BRANCH: begin
        legal  = 1'b1;
        fmt    = IMM_FMT_B;
        sel1   = ALU_SEL1_PC;
        sel2   = ALU_SEL2_IMM;
        branch = 1'b1;
        case (funct3)
          F3_BEQ:  cmp_op = CBU_OP_EQ;
          F3_BNE:  cmp_op = CBU_OP_NE;
          F3_BLT:  cmp_op = CBU_OP_LT;
          F3_BGE:  cmp_op = CBU_OP_GE;
          F3_BLTU: cmp_op = CBU_OP_LTU;
          F3_BGEU: cmp_op = CBU_OP_GEU;
          default: legal  = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal  = 1'b1;
        fmt    = IMM_FMT_I;
        sel2   = ALU_SEL2_IMM;
        wb_sel = WB_SEL_LSU;
        writes = 1'b1;
        case (funct3)
          F3_B:  begin mask = 4'b0001; sext = 1'b1; end
          F3_H:  begin mask = 4'b0011; sext = 1'b1; end
          F3_W:  mask = 4'b1111;
          F3_BU: mask = 4'b0001;
          F3_HU: mask = 4'b0011;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        legal = 1'b1;
        fmt   = IMM_FMT_S;
        sel2  = ALU_SEL2_IMM;
        store = 1'b1;
        case (funct3)
          F3_B:    mask  = 4'b0001;
          F3_H:    mask  = 4'b0011;
          F3_W:    mask  = 4'b1111;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal  = 1'b1;
        fmt    = IMM_FMT_I;
        sel2   = ALU_SEL2_IMM;
        writes = 1'b1;
        alu_op = base_alu_op(funct3);
        // Shift-immediates reuse funct7 as an encoding field, so it must be valid.
        if (funct3 == F3_SLL) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == F3_SRL_SRA) begin
          if (funct7 == F7_ALT) begin
            alu_op = ALU_OP_SRA;
          end else begin
            legal = (funct7 == F7_BASE);
          end
        end
      end
      OPC_OP: begin
        writes = 1'b1;
        if (funct7 == F7_BASE) begin
          legal  = 1'b1;
          alu_op = base_alu_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          legal  = 1'b1;
          alu_op = ALU_OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
          legal  = 1'b1;
          alu_op = ALU_OP_SRA;
        end
`ifdef DECODE_RV32M_EN
        else if (funct7 == F7_MULDIV) begin
          legal  = 1'b1;
          alu_op = ALU_OP_MUL + {2'b00, funct3};
        end
`endif
      end
      default: legal = 1'b0;
    endcase
  end

  // Gate side effects by legality, suppress x0 writes and assemble the entry.
  always_comb begin
    entry         = '0;
    entry.legal   = legal;
    entry.alusel1 = legal ? sel1 : ALU_SEL1_RS1;
    entry.alusel2 = legal ? sel2 : ALU_SEL2_RS2;
    entry.alu_op  = legal ? alu_op : ALU_OP_INV;
    entry.cmp_op  = legal ? cmp_op : CBU_OP_INV;
    entry.branch  = legal && branch;
    entry.jump    = legal && jump;
    entry.wb_sel  = legal ? wb_sel : WB_SEL_ALU;
    entry.rf_we   = legal && writes && (rd != 5'd0);
    entry.lsu_we  = legal && store;
    entry.mask    = legal ? mask : 4'b0000;
    entry.sext    = legal && sext;
    entry.rd      = rd;
    entry.rs1     = instr[19:15];
    entry.rs2     = instr[24:20];
    entry.imm     = legal ? gen_imm(instr[31:7], fmt) : 32'd0;
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched instructions at push time and buffers the
// resulting micro-ops in a DEPTH-entry FIFO with valid/ready on both sides
// and a flush for redirects. Head outputs come only from registers.
// Optional feature macro: DECODE_RV32M_EN (handled inside rv_decode_core).
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  decode_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  decode_entry_t     entry_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  decode_entry_t dec_entry;
  decode_entry_t head_entry;
  logic [ADDR_W-1:0] head_pc;

  logic empty;
  logic full;
  logic push;
  logic pop;

  rv_decode_core u_decode (
    .instr (bus.i_instr),
    .entry (dec_entry)
  );

  assign empty = (count_reg == CNT_W'(0));
  assign full  = (count_reg == CNT_W'(DEPTH));
  // A flush discards any same-cycle transfer in either direction.
  assign push  = bus.i_valid && !full && !bus.i_flush;
  assign pop   = bus.i_ready && !empty && !bus.i_flush;

  // Next pointer/occupancy: flush clears, otherwise advance on push/pop.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  // Pointer/occupancy registers; reset wins over everything else.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Write the decoded micro-op and its PC into the tail slot on a push.
  always_ff @(posedge i_clk) begin
    if (push) begin
      entry_mem[wr_ptr_reg] <= dec_entry;
      pc_mem[wr_ptr_reg]    <= bus.i_pc;
    end
  end

  // Head view: stored entry when non-empty, otherwise the idle pattern.
  always_comb begin
    head_entry = idle_entry();
    head_pc    = '0;
    if (!empty) begin
      head_entry = entry_mem[rd_ptr_reg];
      head_pc    = pc_mem[rd_ptr_reg];
    end
  end

  assign bus.o_ready   = !full;
  assign bus.o_valid   = !empty;
  assign bus.o_count   = count_reg;
  assign bus.o_pc      = head_pc;
  assign bus.o_legal   = head_entry.legal;
  assign bus.o_alusel1 = head_entry.alusel1;
  assign bus.o_alusel2 = head_entry.alusel2;
  assign bus.o_alu_op  = head_entry.alu_op;
  assign bus.o_cmp_op  = head_entry.cmp_op;
  assign bus.o_branch  = head_entry.branch;
  assign bus.o_jump    = head_entry.jump;
  assign bus.o_wb_sel  = head_entry.wb_sel;
  assign bus.o_rf_we   = head_entry.rf_we;
  assign bus.o_lsu_we  = head_entry.lsu_we;
  assign bus.o_mask    = head_entry.mask;
  assign bus.o_sext    = head_entry.sext;
  assign bus.o_rd      = head_entry.rd;
  assign bus.o_rs1     = head_entry.rs1;
  assign bus.o_rs2     = head_entry.rs2;
  assign bus.o_imm     = head_entry.imm;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios followed by
// randomized traffic, all checked against an ISA-table reference model.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  decode_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef enum {C_ILL, C_R, C_IA, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC} cls_e;

  typedef struct {
    decode_entry_t e;
    logic [31:0]   pc;
  } tb_item_t;

  tb_item_t model[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the RV32I/M encoding tables.
  function automatic decode_entry_t ref_decode(input logic [31:0] ins);
    decode_entry_t e;
    cls_e c = C_ILL;
    logic [4:0] op = ALU_OP_ADD;
    logic [2:0] cmp = CBU_OP_INV;
    logic [3:0] msk = 4'b0000;
    logic sx = 1'b0;
    int v = 0;
    casez (ins)
      32'b0000000_?????_?????_000_?????_0110011: begin c = C_R; op = ALU_OP_ADD;  end
      32'b0100000_?????_?????_000_?????_0110011: begin c = C_R; op = ALU_OP_SUB;  end
      32'b0000000_?????_?????_001_?????_0110011: begin c = C_R; op = ALU_OP_SLL;  end
      32'b0000000_?????_?????_010_?????_0110011: begin c = C_R; op = ALU_OP_SLT;  end
      32'b0000000_?????_?????_011_?????_0110011: begin c = C_R; op = ALU_OP_SLTU; end
      32'b0000000_?????_?????_100_?????_0110011: begin c = C_R; op = ALU_OP_XOR;  end
      32'b0000000_?????_?????_101_?????_0110011: begin c = C_R; op = ALU_OP_SRL;  end
      32'b0100000_?????_?????_101_?????_0110011: begin c = C_R; op = ALU_OP_SRA;  end
      32'b0000000_?????_?????_110_?????_0110011: begin c = C_R; op = ALU_OP_OR;   end
      32'b0000000_?????_?????_111_?????_0110011: begin c = C_R; op = ALU_OP_AND;  end
`ifdef DECODE_RV32M_EN
      32'b0000001_?????_?????_000_?????_0110011: begin c = C_R; op = ALU_OP_MUL;    end
      32'b0000001_?????_?????_001_?????_0110011: begin c = C_R; op = ALU_OP_MULH;   end
      32'b0000001_?????_?????_010_?????_0110011: begin c = C_R; op = ALU_OP_MULHSU; end
      32'b0000001_?????_?????_011_?????_0110011: begin c = C_R; op = ALU_OP_MULHU;  end
      32'b0000001_?????_?????_100_?????_0110011: begin c = C_R; op = ALU_OP_DIV;    end
      32'b0000001_?????_?????_101_?????_0110011: begin c = C_R; op = ALU_OP_DIVU;   end
      32'b0000001_?????_?????_110_?????_0110011: begin c = C_R; op = ALU_OP_REM;    end
      32'b0000001_?????_?????_111_?????_0110011: begin c = C_R; op = ALU_OP_REMU;   end
`endif
      32'b????????????_?????_000_?????_0010011:  begin c = C_IA; op = ALU_OP_ADD;  end
      32'b????????????_?????_010_?????_0010011:  begin c = C_IA; op = ALU_OP_SLT;  end
      32'b????????????_?????_011_?????_0010011:  begin c = C_IA; op = ALU_OP_SLTU; end
      32'b????????????_?????_100_?????_0010011:  begin c = C_IA; op = ALU_OP_XOR;  end
      32'b????????????_?????_110_?????_0010011:  begin c = C_IA; op = ALU_OP_OR;   end
      32'b????????????_?????_111_?????_0010011:  begin c = C_IA; op = ALU_OP_AND;  end
      32'b0000000_?????_?????_001_?????_0010011: begin c = C_IA; op = ALU_OP_SLL;  end
      32'b0000000_?????_?????_101_?????_0010011: begin c = C_IA; op = ALU_OP_SRL;  end
      32'b0100000_?????_?????_101_?????_0010011: begin c = C_IA; op = ALU_OP_SRA;  end
      32'b????????????_?????_000_?????_0000011:  begin c = C_LD; msk = 4'b0001; sx = 1'b1; end
      32'b????????????_?????_001_?????_0000011:  begin c = C_LD; msk = 4'b0011; sx = 1'b1; end
      32'b????????????_?????_010_?????_0000011:  begin c = C_LD; msk = 4'b1111; end
      32'b????????????_?????_100_?????_0000011:  begin c = C_LD; msk = 4'b0001; end
      32'b????????????_?????_101_?????_0000011:  begin c = C_LD; msk = 4'b0011; end
      32'b????????????_?????_000_?????_0100011:  begin c = C_ST; msk = 4'b0001; end
      32'b????????????_?????_001_?????_0100011:  begin c = C_ST; msk = 4'b0011; end
      32'b????????????_?????_010_?????_0100011:  begin c = C_ST; msk = 4'b1111; end
      32'b????????????_?????_000_?????_1100011:  begin c = C_BR; cmp = CBU_OP_EQ;  end
      32'b????????????_?????_001_?????_1100011:  begin c = C_BR; cmp = CBU_OP_NE;  end
      32'b????????????_?????_100_?????_1100011:  begin c = C_BR; cmp = CBU_OP_LT;  end
      32'b????????????_?????_101_?????_1100011:  begin c = C_BR; cmp = CBU_OP_GE;  end
      32'b????????????_?????_110_?????_1100011:  begin c = C_BR; cmp = CBU_OP_LTU; end
      32'b????????????_?????_111_?????_1100011:  begin c = C_BR; cmp = CBU_OP_GEU; end
      32'b????????????????????_?????_1101111:    c = C_JAL;
      32'b????????????_?????_000_?????_1100111:  c = C_JALR;
      32'b????????????????????_?????_0110111:    c = C_LUI;
      32'b????????????????????_?????_0010111:    c = C_AUIPC;
      default:                                   c = C_ILL;
    endcase

    e = '0;
    e.alu_op = ALU_OP_INV;
    e.cmp_op = CBU_OP_INV;
    if (c != C_ILL) begin
      e.legal   = 1'b1;
      e.alu_op  = (c == C_R || c == C_IA) ? op : ALU_OP_ADD;
      e.cmp_op  = cmp;
      e.alusel1 = (c == C_BR || c == C_JAL || c == C_AUIPC) ? ALU_SEL1_PC :
                  (c == C_LUI) ? ALU_SEL1_ZERO : ALU_SEL1_RS1;
      e.alusel2 = (c == C_R) ? ALU_SEL2_RS2 : ALU_SEL2_IMM;
      e.wb_sel  = (c == C_LD) ? WB_SEL_LSU : (c == C_JAL || c == C_JALR) ? WB_SEL_PC4 : WB_SEL_ALU;
      e.rf_we   = (c != C_ST && c != C_BR) && (ins[11:7] != 5'd0);
      e.lsu_we  = (c == C_ST);
      e.branch  = (c == C_BR);
      e.jump    = (c == C_JAL || c == C_JALR);
      e.mask    = msk;
      e.sext    = sx;
      case (c)
        C_IA, C_LD, C_JALR: v = $signed(ins[31:20]);
        C_ST:               v = $signed({ins[31:25], ins[11:7]});
        C_BR:               v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        C_JAL:              v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        C_LUI, C_AUIPC:     v = int'(ins[31:12]) * 4096;
        default:            v = 0;
      endcase
      e.imm = 32'(v);
    end
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    return e;
  endfunction

  // Random instruction biased towards valid opcodes and interesting funct7 values.
  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom();
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'b0110111;
      1: w[6:0] = 7'b0010111;
      2: w[6:0] = 7'b1101111;
      3: w[6:0] = 7'b1100111;
      4: w[6:0] = 7'b1100011;
      5: w[6:0] = 7'b0000011;
      6: w[6:0] = 7'b0100011;
      7: w[6:0] = 7'b0010011;
      8: w[6:0] = 7'b0110011;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'b0000000;
      1: w[31:25] = 7'b0100000;
      2: w[31:25] = 7'b0000001;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    decode_entry_t exp;
    logic [31:0] exp_pc;
    exp = '0;
    exp.alu_op = ALU_OP_INV;
    exp.cmp_op = CBU_OP_INV;
    exp_pc = '0;
    if (model.size() > 0) begin
      exp    = model[0].e;
      exp_pc = model[0].pc;
    end
    check("valid",   bus.o_valid,   model.size() > 0);
    check("ready",   bus.o_ready,   model.size() < DEPTH);
    check("count",   bus.o_count,   model.size());
    check("pc",      bus.o_pc,      exp_pc);
    check("legal",   bus.o_legal,   exp.legal);
    check("alusel1", bus.o_alusel1, exp.alusel1);
    check("alusel2", bus.o_alusel2, exp.alusel2);
    check("alu_op",  bus.o_alu_op,  exp.alu_op);
    check("cmp_op",  bus.o_cmp_op,  exp.cmp_op);
    check("branch",  bus.o_branch,  exp.branch);
    check("jump",    bus.o_jump,    exp.jump);
    check("wb_sel",  bus.o_wb_sel,  exp.wb_sel);
    check("rf_we",   bus.o_rf_we,   exp.rf_we);
    check("lsu_we",  bus.o_lsu_we,  exp.lsu_we);
    check("mask",    bus.o_mask,    exp.mask);
    check("sext",    bus.o_sext,    exp.sext);
    check("rd",      bus.o_rd,      exp.rd);
    check("rs1",     bus.o_rs1,     exp.rs1);
    check("rs2",     bus.o_rs2,     exp.rs2);
    check("imm",     bus.o_imm,     exp.imm);
  endtask

  // Drive one cycle, predict the queue contents after the edge, then check.
  task automatic tick(input logic rst, input logic flush, input logic valid,
                      input logic [31:0] instr, input logic [31:0] pc, input logic ready);
    tb_item_t it;
    bit do_push;
    bit do_pop;
    i_rst       = rst;
    bus.i_flush = flush;
    bus.i_valid = valid;
    bus.i_instr = instr;
    bus.i_pc    = pc;
    bus.i_ready = ready;
    do_pop  = (model.size() > 0) && ready;
    do_push = valid && (model.size() < DEPTH);
    if (rst || flush) begin
      model.delete();
    end else begin
      if (do_pop) begin
        $display("txn pop  pc=%08h legal=%0d alu_op=%0d imm=%08h",
                 model[0].pc, model[0].e.legal, model[0].e.alu_op, model[0].e.imm);
        void'(model.pop_front());
      end
      if (do_push) begin
        it.e  = ref_decode(instr);
        it.pc = pc;
        model.push_back(it);
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic idle(input logic ready);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ready);
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic ready);
    tick(1'b0, 1'b0, 1'b1, instr, pc, ready);
  endtask

  initial begin
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_instr = '0;
    bus.i_pc    = '0;
    bus.i_ready = 1'b0;

    // Reset with a push attempt pending: nothing may be stored.
    tick(1'b1, 1'b0, 1'b1, 32'h00500093, 32'h100, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_valid",  bus.o_valid,  1'b0);
    check("rst_ready",  bus.o_ready,  1'b1);
    check("rst_count",  bus.o_count,  0);
    check("rst_alu_op", bus.o_alu_op, ALU_OP_INV);
    check("rst_cmp_op", bus.o_cmp_op, CBU_OP_INV);

    // addi x1,x0,5 with execute ready: visible one edge later, then consumed.
    push(32'h00500093, 32'h1000, 1'b1);
    check("addi_valid", bus.o_valid,  1'b1);
    check("addi_op",    bus.o_alu_op, ALU_OP_ADD);
    check("addi_imm",   bus.o_imm,    32'd5);
    check("addi_rd",    bus.o_rd,     5'd1);
    check("addi_we",    bus.o_rf_we,  1'b1);
    check("addi_count", bus.o_count,  1);
    idle(1'b1);
    check("addi_empty", bus.o_valid,  1'b0);

    // Fill, hold off a third push, then drain across the pointer wrap.
    push(32'h00100113, 32'h2000, 1'b0);
    push(32'h00200193, 32'h2004, 1'b0);
    check("full_ready", bus.o_ready, 1'b0);
    check("full_count", bus.o_count, 2);
    push(32'h00300213, 32'h2008, 1'b0);
    check("held_count", bus.o_count, 2);
    check("held_head",  bus.o_pc,    32'h2000);
    idle(1'b1);
    check("order_pc",   bus.o_pc,    32'h2004);
    idle(1'b1);

    // lb then lbu with the same offset; second pushed while first pops.
    push(32'hFFC18103, 32'h3000, 1'b0);
    check("lb_sext", bus.o_sext, 1'b1);
    check("lb_mask", bus.o_mask, 4'b0001);
    check("lb_imm",  bus.o_imm,  32'hFFFFFFFC);
    push(32'hFFC1C103, 32'h3004, 1'b1);
    check("lbu_sext", bus.o_sext, 1'b0);
    check("lbu_imm",  bus.o_imm,  32'hFFFFFFFC);
    idle(1'b1);

    // add x0 suppresses the write; all-ones is illegal with no side effects.
    push(32'h00208033, 32'h4000, 1'b0);
    check("x0_legal", bus.o_legal, 1'b1);
    check("x0_we",    bus.o_rf_we, 1'b0);
    push(32'hFFFFFFFF, 32'h4004, 1'b1);
    check("ill_legal",  bus.o_legal,  1'b0);
    check("ill_effect", {bus.o_rf_we, bus.o_lsu_we, bus.o_branch, bus.o_jump}, 4'b0000);
    idle(1'b1);

    // Flush on a full queue with a same-cycle push and pop.
    push(32'h00100093, 32'h5000, 1'b0);
    push(32'h00200093, 32'h5004, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'h00300093, 32'h5008, 1'b1);
    check("flush_valid", bus.o_valid, 1'b0);
    check("flush_count", bus.o_count, 0);
    idle(1'b0);
    check("flush_nostore", bus.o_count, 0);

    // mul x1,x2,x3
    push(32'h023100B3, 32'h6000, 1'b0);
`ifdef DECODE_RV32M_EN
    check("mul_legal", bus.o_legal,  1'b1);
    check("mul_op",    bus.o_alu_op, ALU_OP_MUL);
`else
    check("mul_legal", bus.o_legal,  1'b0);
`endif
    // Reset mid-stream drops the entry and overrides a concurrent push.
    tick(1'b1, 1'b1, 1'b1, 32'h00100093, 32'h6004, 1'b0);
    check("mrst_count", bus.o_count, 0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic with occasional flushes and resets.
    for (int n = 0; n < 2500; n++) begin
      int unsigned r;
      r = $urandom_range(0, 999);
      tick(r < 5, (r >= 5 && r < 25), $urandom_range(0, 3) != 0,
           rand_instr(), $urandom(), $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Next-generation decode stage for the RV32I core: combinational instruction decode plus immediate generation and register-index extraction, with results held in a parametrised FIFO of decoded micro-ops.
- Sits between fetch and execute. Valid/ready handshakes on both sides decouple fetch from execute stalls. A flush input supports branch/jump redirects.
- Adds over the previous decoder: load sign-extension flag, rd==x0 write suppression, and per-format immediates.

Parameters:
- DEPTH, 2, number of queue entries; power of two, >= 2.
- ADDR_W, 32, width of the PC carried with each entry.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  synchronous reset, active-high
- i_flush  input  1  discard all queued entries and any same-cycle input
- i_valid  input  1  fetch presents an instruction
- o_ready  output  1  queue can accept; equals !full
- i_instr  input  32  raw instruction
- i_pc  input  ADDR_W  PC of i_instr
- o_valid  output  1  head entry valid; equals !empty
- i_ready  input  1  execute consumes the head entry
- o_pc  output  ADDR_W  head PC
- o_legal  output  1  head instruction legal
- o_alusel1  output  2  ALU operand 1 select
- o_alusel2  output  2  ALU operand 2 select
- o_alu_op  output  5  ALU op code; widened for M-extension codes
- o_cmp_op  output  3  branch compare op
- o_branch  output  1  conditional branch
- o_jump  output  1  JAL/JALR
- o_wb_sel  output  2  write-back source
- o_rf_we  output  1  register file write enable
- o_lsu_we  output  1  store
- o_mask  output  4  byte mask for load/store
- o_sext  output  1  load result is sign-extended
- o_rd  output  5  destination register index
- o_rs1  output  5  source register 1 index
- o_rs2  output  5  source register 2 index
- o_imm  output  32  sign-extended immediate for the instruction format
- o_count  output  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (i_rst=1 at an edge): read/write pointers and count cleared.
  - o_valid=0, o_ready=1, o_count=0.
  - All head fields read as zero; o_alu_op=ALU_OP_INV, o_cmp_op=CBU_OP_INV.
  - Reset mid-stream drops all entries; reset takes priority over flush and push/pop.
- Push: i_valid && o_ready. Decode is computed combinationally from i_instr at the push cycle and written with i_pc into the tail entry.
- Pop: o_valid && i_ready. Head advances.
- Latency: instruction pushed at edge N is visible at the head (o_valid=1) after edge N when the queue was empty. No combinational input-to-output path.
- Concurrency and wrap:
  - Push and pop in the same cycle leave the count unchanged.
  - Full: o_ready=0, so no push; pop still allowed.
  - Empty: pop not possible.
  - Pointers wrap modulo DEPTH.
- Flush: at the edge, count and pointers are cleared; a same-cycle push and pop are both ignored. o_valid=0 on the next cycle.
- Head outputs are zero whenever o_valid=0.
- Decode rules match the existing decoder encoding constants, with these additions:
  - Illegal instruction: o_legal=0, and rf_we, lsu_we, branch and jump are all 0.
  - o_rf_we is forced to 0 when rd==0.
  - Loads: o_sext=1 for LB/LH, 0 for LBU/LHU/LW and for all non-loads.
  - o_imm by format:
    - I: sign-extended instr[31:20]
    - S: sign-extended {instr[31:25], instr[11:7]}
    - B: sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}
    - J: sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}
    - U: {instr[31:12], 12'b0}
    - R/illegal: 0
  - o_rd, o_rs1 and o_rs2 are always raw fields instr[11:7], [19:15] and [24:20].
- o_count: 0..DEPTH, updated at every edge.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to ALU_OP_MUL..ALU_OP_REMU (5-bit codes 16..23), with o_rf_we=1 and o_wb_sel=WB_SEL_ALU.
- Undefined: those encodings are illegal (o_legal=0).

Decomposition:
- Shared header decoder.vh holds:
  - opcode, funct3 and funct7 constants, including the M-extension funct7
  - ALU_OP_* (now 5-bit) and CBU_OP_* codes
  - ALU_SEL1_*, ALU_SEL2_* and WB_SEL_* selects
  - an IMM_FMT_* enumeration (I, S, B, J, U, NONE)
- One sub-module: rv_decode_core, a purely combinational decode and immediate generator producing one entry. decode_queue instantiates it on the input side and adds the storage, pointers and handshakes.

Test Plan:
- Reset, then push addi x1,x0,5 (0x00500093) with i_ready=1 -> next cycle o_valid=1, o_alu_op=ALU_OP_ADD, o_imm=5, o_rd=1, o_rf_we=1, o_count=1; then empty.
- Push DEPTH=2 instructions with i_ready=0 -> o_ready=0 and o_count=2; a third push is held off; raise i_ready -> FIFO order preserved and pointer wraps.
- Push lb x2,-4(x3) (0xFFC18103) -> o_sext=1, o_mask=0001, o_imm=0xFFFFFFFC; lbu same offset (0xFFC1C103) -> o_sext=0.
- Push add x0,x1,x2 (0x00208033) -> o_legal=1, o_rf_we=0; push 0xFFFFFFFF -> o_legal=0 with all side-effect enables 0.
- Full queue plus i_flush with i_valid=1 and i_ready=1 -> next cycle o_valid=0, o_count=0, and the input is not stored.
- mul x1,x2,x3 (0x023100B3) -> o_alu_op=ALU_OP_MUL with DECODE_RV32M_EN defined; o_legal=0 without it.
